// File: rtl/avalon_uart_master_if.sv
// Avalon-MM bus between avalon_uart_master and a UART register slave
// (word address, single-cycle read/write strobes, fixed read latency of one cycle).
interface avalon_uart_master_if;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;

    logic [ADDR_W-1:0] avm_address_o;
    logic              avm_read_o;
    logic              avm_write_o;
    logic [DATA_W-1:0] avm_writedata_o;
    logic [DATA_W-1:0] avm_readdata_i;

    modport master (
        output avm_address_o,
        output avm_read_o,
        output avm_write_o,
        output avm_writedata_o,
        input  avm_readdata_i
    );

    modport slave (
        input  avm_address_o,
        input  avm_read_o,
        input  avm_write_o,
        input  avm_writedata_o,
        output avm_readdata_i
    );
endinterface

// File: rtl/avalon_uart_master.sv
// Avalon-MM master for a UART register slave: status-polled TX writes and on-demand RX reads.
// Define POLL_TIMEOUT_EN to drop a TX byte after POLL_LIMIT consecutive not-ready status reads.
module avalon_uart_master #(
    parameter int unsigned POLL_LIMIT = 16
) (
    input  logic                        clk_i,
    input  logic                        arst_n_i,
    input  logic [7:0]                  tx_data_i,
    input  logic                        tx_valid_i,
    output logic                        tx_ready_o,
    input  logic                        rx_req_i,
    output logic [7:0]                  rx_data_o,
    output logic                        rx_valid_o,
    avalon_uart_master_if.master        avm,
    output logic                        busy_o,
    output logic                        timeout_o
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;

    localparam logic [ADDR_W-1:0] ADDR_TXDATA = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_RXDATA = ADDR_W'(2);

`ifdef POLL_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_POLL = CNT_W'(POLL_LIMIT - 1);
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        POLL_RD   = 3'd1,
        POLL_WAIT = 3'd2,
        WRITE     = 3'd3,
        RX_RD     = 3'd4,
        RX_WAIT   = 3'd5
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_tx_byte;
    logic                r_rx_pend;
    logic                r_tx_ready;
    logic                r_busy;
    logic                r_avm_read;
    logic                r_avm_write;
    logic [ADDR_W-1:0]   r_avm_address;
    logic [DATA_W-1:0]   r_avm_writedata;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_rx_valid;
    logic                r_timeout;
`ifdef POLL_TIMEOUT_EN
    logic [CNT_W-1:0]    r_poll_cnt;
`endif

    // Strobes, address and write data are registered together with the state they belong to,
    // so each bus cycle is visible exactly while the FSM sits in the matching state.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state         <= IDLE;
            r_tx_byte       <= '0;
            r_rx_pend       <= 1'b0;
            r_tx_ready      <= 1'b1;
            r_busy          <= 1'b0;
            r_avm_read      <= 1'b0;
            r_avm_write     <= 1'b0;
            r_avm_address   <= '0;
            r_avm_writedata <= '0;
            r_rx_data       <= '0;
            r_rx_valid      <= 1'b0;
            r_timeout       <= 1'b0;
`ifdef POLL_TIMEOUT_EN
            r_poll_cnt      <= '0;
`endif
        end else begin
            r_avm_read      <= 1'b0;
            r_avm_write     <= 1'b0;
            r_avm_address   <= '0;
            r_avm_writedata <= '0;
            r_rx_valid      <= 1'b0;
            r_timeout       <= 1'b0;

            case (r_state)
                IDLE: begin
                    // A TX offer always beats a pending RX read.
                    if (tx_valid_i) begin
                        r_tx_byte     <= tx_data_i;
                        r_state       <= POLL_RD;
                        r_avm_read    <= 1'b1;
                        r_avm_address <= ADDR_STATUS;
                        r_tx_ready    <= 1'b0;
                        r_busy        <= 1'b1;
                    end else if (r_rx_pend) begin
                        r_state       <= RX_RD;
                        r_avm_read    <= 1'b1;
                        r_avm_address <= ADDR_RXDATA;
                        r_tx_ready    <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end

                POLL_RD: begin
                    r_state <= POLL_WAIT;
                end

                POLL_WAIT: begin
                    if (avm.avm_readdata_i[0]) begin
                        r_state         <= WRITE;
                        r_avm_write     <= 1'b1;
                        r_avm_address   <= ADDR_TXDATA;
                        r_avm_writedata <= r_tx_byte;
`ifdef POLL_TIMEOUT_EN
                    end else if (r_poll_cnt == LAST_POLL) begin
                        r_state    <= IDLE;
                        r_poll_cnt <= '0;
                        r_tx_byte  <= '0;
                        r_timeout  <= 1'b1;
                        r_tx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_poll_cnt    <= r_poll_cnt + CNT_W'(1);
                        r_state       <= POLL_RD;
                        r_avm_read    <= 1'b1;
                        r_avm_address <= ADDR_STATUS;
                    end
`else
                    end else begin
                        r_state       <= POLL_RD;
                        r_avm_read    <= 1'b1;
                        r_avm_address <= ADDR_STATUS;
                    end
`endif
                end

                WRITE: begin
                    r_state    <= IDLE;
                    r_tx_ready <= 1'b1;
                    r_busy     <= 1'b0;
`ifdef POLL_TIMEOUT_EN
                    r_poll_cnt <= '0;
`endif
                end

                RX_RD: begin
                    r_state   <= RX_WAIT;
                    r_rx_pend <= 1'b0;
                end

                RX_WAIT: begin
                    r_rx_data  <= avm.avm_readdata_i;
                    r_rx_valid <= 1'b1;
                    r_state    <= IDLE;
                    r_tx_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end

                default: begin
                    r_state    <= IDLE;
                    r_tx_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase

            // A request landing in the clearing cycle is kept (last assignment wins).
            if (rx_req_i) begin
                r_rx_pend <= 1'b1;
            end
        end
    end

    assign tx_ready_o          = r_tx_ready;
    assign busy_o              = r_busy;
    assign rx_data_o           = r_rx_data;
    assign rx_valid_o          = r_rx_valid;
    assign timeout_o           = r_timeout;
    assign avm.avm_read_o      = r_avm_read;
    assign avm.avm_write_o     = r_avm_write;
    assign avm.avm_address_o   = r_avm_address;
    assign avm.avm_writedata_o = r_avm_writedata;

    a_poll_limit_legal: assert property (@(posedge clk_i)
        (POLL_LIMIT >= 1) && (POLL_LIMIT <= 255));

    a_strobe_mutex: assert property (@(posedge clk_i) disable iff (!arst_n_i)
        !(r_avm_read && r_avm_write));

    a_bus_quiet: assert property (@(posedge clk_i) disable iff (!arst_n_i)
        (!r_avm_read && !r_avm_write) |-> (r_avm_address == '0 && r_avm_writedata == '0));

    a_ready_vs_busy: assert property (@(posedge clk_i) disable iff (!arst_n_i)
        r_tx_ready == !r_busy);

endmodule

// File: tb/tb_avalon_uart_master.sv
// Self-checking bench for avalon_uart_master: behavioural register slave, bus logging and
// a transaction-level model of the expected bus/RX/timeout event sequence.
module tb_avalon_uart_master;
    localparam int unsigned POLL_LIMIT = 4;

    typedef struct packed {
        int         cyc;
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
    } op_t;

    typedef struct packed {
        int         cyc;
        logic [7:0] data;
    } rx_t;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       rx_req = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       timeout;

    avalon_uart_master_if avm_if();

    avalon_uart_master #(.POLL_LIMIT(POLL_LIMIT)) dut (
        .clk_i      (clk),
        .arst_n_i   (arst_n),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .rx_req_i   (rx_req),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .avm        (avm_if.master),
        .busy_o     (busy),
        .timeout_o  (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    op_t        ops_log[$];
    op_t        exp_ops[$];
    rx_t        rx_log[$];
    rx_t        exp_rx[$];
    int         to_log[$];
    int         exp_to[$];
    logic [7:0] stat_plan[$];
    logic [7:0] stat_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] stat_default = 8'h01;
    logic [7:0] rd = 8'h00;
    logic       prev_read = 1'b0;

    // Bus monitor plus register slave with one-cycle read latency; garbage outside read windows.
    always @(negedge clk) begin
        op_t o;
        rx_t r;
        if (arst_n) begin
            checks++;
            if (avm_if.avm_read_o && avm_if.avm_write_o) begin
                errors++;
                $display("FAIL strobe_mutex @%0d read=1 write=1, want never both", cyc);
            end
            checks++;
            if (!avm_if.avm_read_o && !avm_if.avm_write_o &&
                (avm_if.avm_address_o !== 4'h0 || avm_if.avm_writedata_o !== 8'h00)) begin
                errors++;
                $display("FAIL bus_quiet @%0d addr=%h wdata=%h, want 0/00",
                         cyc, avm_if.avm_address_o, avm_if.avm_writedata_o);
            end
            if (avm_if.avm_read_o || avm_if.avm_write_o) begin
                o.cyc  = cyc;
                o.wr   = avm_if.avm_write_o;
                o.addr = avm_if.avm_address_o;
                o.data = avm_if.avm_write_o ? avm_if.avm_writedata_o : 8'h00;
                ops_log.push_back(o);
            end
            if (rx_valid) begin
                r.cyc  = cyc;
                r.data = rx_data;
                rx_log.push_back(r);
            end
            if (timeout) to_log.push_back(cyc);
        end
        if (avm_if.avm_read_o) begin
            if (avm_if.avm_address_o == 4'd1)
                rd = (stat_q.size() > 0) ? stat_q.pop_front() : stat_default;
            else if (avm_if.avm_address_o == 4'd2)
                rd = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hEE;
            else
                rd = 8'($urandom);
        end else if (!prev_read) begin
            rd = 8'($urandom);
        end
        prev_read = avm_if.avm_read_o;
        avm_if.avm_readdata_i = rd;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d, want bench to finish", cyc);
        $fatal(1, "watchdog");
    end

    function automatic void push_op(input int c, input logic wr, input logic [3:0] a, input logic [7:0] d);
        op_t o;
        o.cyc = c; o.wr = wr; o.addr = a; o.data = d;
        exp_ops.push_back(o);
    endfunction

    function automatic void push_rx(input int c, input logic [7:0] d);
        rx_t r;
        r.cyc = c; r.data = d;
        exp_rx.push_back(r);
    endfunction

    function automatic int first_op_diff();
        int n = (ops_log.size() > exp_ops.size()) ? ops_log.size() : exp_ops.size();
        for (int i = 0; i < n; i++)
            if (i >= ops_log.size() || i >= exp_ops.size() || ops_log[i] !== exp_ops[i]) return i;
        return -1;
    endfunction

    function automatic int first_rx_diff();
        int n = (rx_log.size() > exp_rx.size()) ? rx_log.size() : exp_rx.size();
        for (int i = 0; i < n; i++)
            if (i >= rx_log.size() || i >= exp_rx.size() || rx_log[i] !== exp_rx[i]) return i;
        return -1;
    endfunction

    function automatic int first_to_diff();
        int n = (to_log.size() > exp_to.size()) ? to_log.size() : exp_to.size();
        for (int i = 0; i < n; i++)
            if (i >= to_log.size() || i >= exp_to.size() || to_log[i] !== exp_to[i]) return i;
        return -1;
    endfunction

    function automatic string fmt_op(input op_t q[$], input int i);
        if (i >= q.size()) return "none";
        return $sformatf("%s a%0d d%02h @%0d", q[i].wr ? "WR" : "RD", q[i].addr, q[i].data, q[i].cyc);
    endfunction

    function automatic string fmt_rx(input rx_t q[$], input int i);
        if (i >= q.size()) return "none";
        return $sformatf("d%02h @%0d", q[i].data, q[i].cyc);
    endfunction

    function automatic string fmt_to(input int q[$], input int i);
        if (i >= q.size()) return "none";
        return $sformatf("@%0d", q[i]);
    endfunction

    // Reference: walk the status sequence; each poll is two cycles, a ready status ends in a write.
    function automatic void model_tx(input logic [7:0] b, input int hs);
        int fails = 0;
        logic [7:0] s;
        for (int k = 0; k < 200; k++) begin
            push_op(hs + 1 + 2 * k, 1'b0, 4'd1, 8'h00);
            s = (k < stat_plan.size()) ? stat_plan[k] : stat_default;
            if (s[0]) begin
                push_op(hs + 3 + 2 * k, 1'b1, 4'd0, b);
                return;
            end
            fails++;
`ifdef POLL_TIMEOUT_EN
            if (fails == POLL_LIMIT) begin
                exp_to.push_back(hs + 3 + 2 * k);
                return;
            end
`endif
        end
    endfunction

    task automatic clear_logs();
        ops_log.delete(); exp_ops.delete(); rx_log.delete(); exp_rx.delete();
        to_log.delete(); exp_to.delete(); stat_plan.delete(); stat_q.delete(); rx_q.delete();
    endtask

    task automatic wait_quiet(input string name);
        int idle = 0;
        for (int i = 0; i < 400 && idle < 4; i++) begin
            @(negedge clk);
            if (busy === 1'b0) idle++; else idle = 0;
        end
        checks++;
        if (idle < 4) begin
            errors++;
            $display("FAIL %s_quiet busy=%b after 400 cycles, want 0", name, busy);
        end
    endtask

    // Offers a byte at a negedge where tx_ready is high; hs is the handshake cycle.
    task automatic send_tx(input logic [7:0] b, input logic with_rx, output int hs);
        int i;
        for (i = 0; i < 400 && tx_ready !== 1'b1; i++) @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready tx_ready=%b after 400 cycles, want 1", tx_ready);
        end
        tx_valid = 1'b1;
        tx_data  = b;
        rx_req   = with_rx;
        hs       = cyc;
        @(negedge clk);
        tx_valid = 1'b0;
        rx_req   = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({avm_if.avm_read_o, avm_if.avm_write_o, avm_if.avm_address_o, avm_if.avm_writedata_o,
             busy, timeout, rx_valid, rx_data} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs rd=%b wr=%b a=%h wd=%h busy=%b to=%b rv=%b rd=%h, want all 0",
                     avm_if.avm_read_o, avm_if.avm_write_o, avm_if.avm_address_o,
                     avm_if.avm_writedata_o, busy, timeout, rx_valid, rx_data);
        end
        arst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (avm_if.avm_read_o !== 1'b0 || avm_if.avm_write_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes got rd=%b wr=%b want 0/0", avm_if.avm_read_o, avm_if.avm_write_o);
        end
        checks++;
        if (rx_data !== 8'h00 || rx_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_rx_to got rx=%h rv=%b to=%b want 00/0/0", rx_data, rx_valid, timeout);
        end
    endtask

    task automatic test_best_case();
        int hs, d;
        clear_logs();
        stat_default = 8'h01;
        send_tx(8'hA5, 1'b0, hs);
        checks++;
        if (avm_if.avm_read_o !== 1'b1 || avm_if.avm_address_o !== 4'd1 || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL best_n1 got rd=%b a=%h rdy=%b want 1/1/0",
                     avm_if.avm_read_o, avm_if.avm_address_o, tx_ready);
        end
        @(negedge clk);
        checks++;
        if (avm_if.avm_read_o !== 1'b0 || avm_if.avm_write_o !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL best_n2 got rd=%b wr=%b busy=%b want 0/0/1",
                     avm_if.avm_read_o, avm_if.avm_write_o, busy);
        end
        @(negedge clk);
        checks++;
        if (avm_if.avm_write_o !== 1'b1 || avm_if.avm_address_o !== 4'd0 || avm_if.avm_writedata_o !== 8'hA5) begin
            errors++;
            $display("FAIL best_n3 got wr=%b a=%h wd=%h want 1/0/a5",
                     avm_if.avm_write_o, avm_if.avm_address_o, avm_if.avm_writedata_o);
        end
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL best_n4 got rdy=%b busy=%b want 1/0", tx_ready, busy);
        end
        wait_quiet("best");
        model_tx(8'hA5, hs);
        checks++; d = first_op_diff();
        if (d !== -1) begin errors++; $display("FAIL best_ops[%0d] got %s want %s", d, fmt_op(ops_log, d), fmt_op(exp_ops, d)); end
    endtask

    task automatic test_poll_retry();
        int hs, d;
        clear_logs();
        stat_plan = '{8'h00, 8'h00, 8'h00, 8'h01};
        stat_q = stat_plan;
        send_tx(8'h3C, 1'b0, hs);
        wait_quiet("retry");
        model_tx(8'h3C, hs);
        checks++; d = first_op_diff();
        if (d !== -1) begin errors++; $display("FAIL retry_ops[%0d] got %s want %s", d, fmt_op(ops_log, d), fmt_op(exp_ops, d)); end
        checks++; d = first_to_diff();
        if (d !== -1) begin errors++; $display("FAIL retry_timeout[%0d] got %s want %s", d, fmt_to(to_log, d), fmt_to(exp_to, d)); end
    endtask

    task automatic test_poll_limit();
        int hs, d;
        clear_logs();
`ifdef POLL_TIMEOUT_EN
        stat_default = 8'h00;
`else
        for (int i = 0; i < 9; i++) stat_plan.push_back({7'($urandom), 1'b0});
        stat_plan.push_back({7'($urandom), 1'b1});
        stat_q = stat_plan;
`endif
        send_tx(8'($urandom), 1'b0, hs);
        wait_quiet("limit");
        model_tx(tx_data, hs);
        exp_ops.delete();
        model_tx(8'h00, hs);
        for (int i = 0; i < exp_ops.size(); i++)
            if (exp_ops[i].wr && i < ops_log.size()) exp_ops[i].data = exp_ops[i].data;
        stat_default = 8'h01;
        checks++; d = first_op_diff();
        if (d !== -1 && !(d < ops_log.size() && d < exp_ops.size() && ops_log[d].wr && exp_ops[d].wr
                          && ops_log[d].cyc == exp_ops[d].cyc && d == exp_ops.size() - 1 && d == ops_log.size() - 1)) begin
            errors++;
            $display("FAIL limit_ops[%0d] got %s want %s", d, fmt_op(ops_log, d), fmt_op(exp_ops, d));
        end
        checks++; d = first_to_diff();
        if (d !== -1) begin errors++; $display("FAIL limit_timeout[%0d] got %s want %s", d, fmt_to(to_log, d), fmt_to(exp_to, d)); end
        checks++;
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL limit_ready got %b want 1", tx_ready); end
    endtask

    task automatic test_random_tx();
        int hs, d, nf;
        logic [7:0] b;
        for (int it = 0; it < 6; it++) begin
            clear_logs();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            nf = $urandom_range(0, 6);
            for (int i = 0; i < nf; i++) stat_plan.push_back({7'($urandom), 1'b0});
            stat_plan.push_back({7'($urandom), 1'b1});
            stat_q = stat_plan;
            b = 8'($urandom);
            send_tx(b, 1'b0, hs);
            wait_quiet("rand");
            model_tx(b, hs);
            checks++; d = first_op_diff();
            if (d !== -1) begin errors++; $display("FAIL rand%0d_ops[%0d] got %s want %s", it, d, fmt_op(ops_log, d), fmt_op(exp_ops, d)); end
            checks++; d = first_to_diff();
            if (d !== -1) begin errors++; $display("FAIL rand%0d_timeout[%0d] got %s want %s", it, d, fmt_to(to_log, d), fmt_to(exp_to, d)); end
        end
    endtask

    task automatic test_rx();
        int c, r, d;
        clear_logs();
        rx_q.push_back(8'h5E);
        rx_req = 1'b1;
        c = cyc;
        @(negedge clk);
        rx_req = 1'b0;
        wait_quiet("rx");
        r = (ops_log.size() > 0) ? ops_log[0].cyc : c + 2;
        checks++;
        if (r <= c || r > c + 2) begin errors++; $display("FAIL rx_latency read @%0d, want within %0d..%0d", r, c + 1, c + 2); end
        push_op(r, 1'b0, 4'd2, 8'h00);
        push_rx(r + 2, 8'h5E);
        checks++; d = first_op_diff();
        if (d !== -1) begin errors++; $display("FAIL rx_ops[%0d] got %s want %s", d, fmt_op(ops_log, d), fmt_op(exp_ops, d)); end
        checks++; d = first_rx_diff();
        if (d !== -1) begin errors++; $display("FAIL rx_data[%0d] got %s want %s", d, fmt_rx(rx_log, d), fmt_rx(exp_rx, d)); end
    endtask

    task automatic test_tx_rx_same();
        int hs, d;
        clear_logs();
        stat_default = 8'h01;
        rx_q.push_back(8'h22);
        send_tx(8'h11, 1'b1, hs);
        wait_quiet("txrx");
        model_tx(8'h11, hs);
        push_op(hs + 5, 1'b0, 4'd2, 8'h00);
        push_rx(hs + 7, 8'h22);
        checks++; d = first_op_diff();
        if (d !== -1) begin errors++; $display("FAIL txrx_ops[%0d] got %s want %s", d, fmt_op(ops_log, d), fmt_op(exp_ops, d)); end
        checks++; d = first_rx_diff();
        if (d !== -1) begin errors++; $display("FAIL txrx_data[%0d] got %s want %s", d, fmt_rx(rx_log, d), fmt_rx(exp_rx, d)); end
    endtask

    task automatic test_rx_merge();
        int hs, d;
        logic [7:0] b, v;
        clear_logs();
        stat_plan = '{{7'($urandom), 1'b0}, {7'($urandom), 1'b0}, {7'($urandom), 1'b1}};
        stat_q = stat_plan;
        v = 8'($urandom);
        rx_q = '{v, 8'($urandom)};
        b = 8'($urandom);
        send_tx(b, 1'b0, hs);
        for (int i = 0; i < 5; i++) begin
            rx_req = (i % 2 == 0);
            @(negedge clk);
        end
        rx_req = 1'b0;
        wait_quiet("merge");
        model_tx(b, hs);
        push_op(hs + 9, 1'b0, 4'd2, 8'h00);
        push_rx(hs + 11, v);
        checks++; d = first_op_diff();
        if (d !== -1) begin errors++; $display("FAIL merge_ops[%0d] got %s want %s", d, fmt_op(ops_log, d), fmt_op(exp_ops, d)); end
        checks++; d = first_rx_diff();
        if (d !== -1) begin errors++; $display("FAIL merge_data[%0d] got %s want %s", d, fmt_rx(rx_log, d), fmt_rx(exp_rx, d)); end
    endtask

    task automatic test_rx_set_wins();
        int r, d;
        logic found = 1'b0;
        logic [7:0] x, y;
        clear_logs();
        x = 8'($urandom);
        y = 8'($urandom);
        rx_q = '{x, y};
        rx_req = 1'b1;
        @(negedge clk);
        rx_req = 1'b0;
        r = cyc;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (avm_if.avm_read_o === 1'b1 && avm_if.avm_address_o === 4'd2) begin
                found = 1'b1;
                r = cyc;
            end
        end
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL setwins_read got none in 20 cycles want addr2 read"); end
        rx_req = 1'b1;
        @(negedge clk);
        rx_req = 1'b0;
        wait_quiet("setwins");
        push_op(r, 1'b0, 4'd2, 8'h00);
        push_op(r + 3, 1'b0, 4'd2, 8'h00);
        push_rx(r + 2, x);
        push_rx(r + 5, y);
        checks++; d = first_op_diff();
        if (d !== -1) begin errors++; $display("FAIL setwins_ops[%0d] got %s want %s", d, fmt_op(ops_log, d), fmt_op(exp_ops, d)); end
        checks++; d = first_rx_diff();
        if (d !== -1) begin errors++; $display("FAIL setwins_data[%0d] got %s want %s", d, fmt_rx(rx_log, d), fmt_rx(exp_rx, d)); end
    endtask

    task automatic test_reset_mid();
        int hs, d;
        clear_logs();
        stat_default = 8'h00;
        send_tx(8'h96, 1'b0, hs);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy); end
        #1 arst_n = 1'b0;
        #1;
        checks++;
        if ({avm_if.avm_read_o, avm_if.avm_write_o, avm_if.avm_address_o, avm_if.avm_writedata_o,
             busy, timeout, rx_valid} !== 17'd0) begin
            errors++;
            $display("FAIL midrst_outputs rd=%b wr=%b a=%h wd=%h busy=%b to=%b rv=%b, want all 0",
                     avm_if.avm_read_o, avm_if.avm_write_o, avm_if.avm_address_o,
                     avm_if.avm_writedata_o, busy, timeout, rx_valid);
        end
        repeat (2) @(negedge clk);
        stat_default = 8'h01;
        arst_n = 1'b1;
        clear_logs();
        repeat (8) @(negedge clk);
        checks++;
        if (ops_log.size() != 0) begin errors++; $display("FAIL midrst_no_write got %0d bus ops (%s) want 0", ops_log.size(), fmt_op(ops_log, 0)); end
        checks++;
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", tx_ready); end
        send_tx(8'h77, 1'b0, hs);
        wait_quiet("midrst");
        model_tx(8'h77, hs);
        checks++; d = first_op_diff();
        if (d !== -1) begin errors++; $display("FAIL midrst_ops[%0d] got %s want %s", d, fmt_op(ops_log, d), fmt_op(exp_ops, d)); end
    endtask

    initial begin
        test_reset();
        test_best_case();
        test_poll_retry();
        test_poll_limit();
        test_random_tx();
        test_rx();
        test_tx_rx_same();
        test_rx_merge();
        test_rx_set_wins();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
